cpu_clock_ctrl: RTL

Board-facing clock/step controller that sits directly upstream of the single-cycle cpu top. It drives the cpu's clk and rst inputs from the 50 MHz board clock and two push-buttons. It supports single-step (HALT) and free-run (RUN) modes. The cpu's synchronous reset is applied with real cpu clock edges, and the number of executed cpu cycles is exported for display.

---
 rtl/cpu_clock_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cpu_clock_ctrl.sv
// Board-side clock/step controller for the single-cycle cpu: debounced step and run/halt keys,
// cpu reset sequencing with real cpu clock pulses, and a count of executed cpu ticks.
module cpu_clock_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 25000000,
  parameter int RST_TICKS       = 2,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_step_n,
  input  logic                 key_run_n,
  output logic                 cpu_clk,
  output logic                 cpu_rst,
  output logic                 running,
  output logic [CNT_WIDTH-1:0] tick_count
);

  localparam int DW  = $clog2(DEBOUNCE_CYCLES);
  localparam int VW  = $clog2(RUN_DIV);
  localparam int RW  = $clog2(RST_TICKS + 2);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [VW-1:0] DIV_MAX = VW'(RUN_DIV - 1);
  localparam logic [RW-1:0] RST_MAX = RW'(RST_TICKS);

  localparam logic [1:0] ST_RST_HOLD = 2'd0;
  localparam logic [1:0] ST_HALT     = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;

  // Key index 0 is step, index 1 is run/halt.
  logic [1:0]          w_keys;
  logic [1:0]          r_s1;
  logic [1:0]          r_s2;
  logic [1:0]          r_deb;
  logic [1:0]          r_deb_q;
  logic [DW-1:0]       r_deb_cnt [2];
  logic [1:0]          w_press;

  logic [1:0]          r_state;
  logic                r_phase;
  logic [RW-1:0]       r_rst_cnt;
  logic [VW-1:0]       r_div;
  logic                r_cpu_clk;
  logic                r_cpu_rst;
  logic                r_running;
  logic [CNT_WIDTH-1:0] r_tick_count;
  logic                w_tick;

  assign w_keys  = {key_run_n, key_step_n};
  assign w_press = ~r_deb & r_deb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 2'b11;
      r_s2    <= 2'b11;
      r_deb   <= 2'b11;
      r_deb_q <= 2'b11;
      for (int k = 0; k < 2; k++) r_deb_cnt[k] <= '0;
    end else begin
      r_s1    <= w_keys;
      r_s2    <= r_s1;
      r_deb_q <= r_deb;
      for (int k = 0; k < 2; k++) begin
        if (r_s2[k] != r_deb[k]) begin
          if (r_deb_cnt[k] == DEB_MAX) begin
            r_deb[k]     <= r_s2[k];
            r_deb_cnt[k] <= '0;
          end else begin
            r_deb_cnt[k] <= r_deb_cnt[k] + 1'b1;
          end
        end else begin
          r_deb_cnt[k] <= '0;
        end
      end
    end
  end

  // A run press always takes priority over a tick in the same cycle.
  always_comb begin
    w_tick = 1'b0;
    case (r_state)
      ST_RST_HOLD: w_tick = !r_phase && (r_rst_cnt != RST_MAX);
      ST_HALT:     w_tick = w_press[0] && !w_press[1];
      ST_RUN:      w_tick = !w_press[1] && (r_div == DIV_MAX);
      default:     w_tick = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RST_HOLD;
      r_phase      <= 1'b0;
      r_rst_cnt    <= '0;
      r_div        <= '0;
      r_cpu_clk    <= 1'b0;
      r_cpu_rst    <= 1'b1;
      r_running    <= 1'b0;
      r_tick_count <= '0;
    end else begin
      r_cpu_clk <= w_tick;
      case (r_state)
        ST_RST_HOLD: begin
          r_phase <= !r_phase;
          if (w_tick) begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end else if (!r_phase && r_rst_cnt == RST_MAX) begin
            // Release one full slot after the last reset pulse so the cpu samples rst high.
            r_state   <= ST_HALT;
            r_cpu_rst <= 1'b0;
          end
        end
        ST_HALT: begin
          if (w_press[1]) begin
            r_state   <= ST_RUN;
            r_div     <= '0;
            r_running <= 1'b1;
          end else if (w_tick) begin
            r_tick_count <= r_tick_count + 1'b1;
          end
        end
        ST_RUN: begin
          if (w_press[1]) begin
            r_state   <= ST_HALT;
            r_div     <= '0;
            r_running <= 1'b0;
          end else if (r_div == DIV_MAX) begin
            r_div        <= '0;
            r_tick_count <= r_tick_count + 1'b1;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: r_state <= ST_RST_HOLD;
      endcase
    end
  end

  assign cpu_clk    = r_cpu_clk;
  assign cpu_rst    = r_cpu_rst;
  assign running    = r_running;
  assign tick_count = r_tick_count;

endmodule
